mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle shared by the CPU, the DMA engine, the memory and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
  parameter int ADR_W  = 12,
  parameter int DATA_W = 16
);
  logic              cpuReq;
  logic              cpuWe;
  logic [ADR_W-1:0]  cpuAdr;
  logic [DATA_W-1:0] cpuWriteData;
  logic              cpuAck;
  logic [DATA_W-1:0] cpuReadData;

  logic              dmaReq;
  logic              dmaWe;
  logic [ADR_W-1:0]  dmaAdr;
  logic [DATA_W-1:0] dmaWriteData;
  logic              dmaAck;
  logic [DATA_W-1:0] dmaReadData;

  logic [DATA_W-1:0] memData;
  logic [ADR_W-1:0]  memAdr;
  logic [DATA_W-1:0] memWriteData;
  logic              memWrite;
  logic              memRead;

  logic              busy;
  logic              grantDma;

  modport slave (
    input  cpuReq, cpuWe, cpuAdr, cpuWriteData,
    input  dmaReq, dmaWe, dmaAdr, dmaWriteData,
    input  memData,
    output cpuAck, cpuReadData, dmaAck, dmaReadData,
    output memAdr, memWriteData, memWrite, memRead,
    output busy, grantDma
  );

  modport master (
    output cpuReq, cpuWe, cpuAdr, cpuWriteData,
    output dmaReq, dmaWe, dmaAdr, dmaWriteData,
    output memData,
    input  cpuAck, cpuReadData, dmaAck, dmaReadData,
    input  memAdr, memWriteData, memWrite, memRead,
    input  busy, grantDma
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for a single memory port; every access is a fixed LATENCY-cycle transaction.
// Define ARB_FIXED_PRIORITY_EN to make the CPU win every tie (default: round-robin).
module mem_port_arbiter #(
  parameter int ADR_W   = 12,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | no transaction; arbitration happens only here
  // ACCESS | strobes held from latched request, wait counter running down
  // DONE   | one-cycle ack to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_dma_q, grant_dma_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              pick_dma;

  always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
    pick_dma = bus.dmaReq && !bus.cpuReq;
`else
    // on a tie the requester that did not win last time gets the port
    pick_dma = bus.dmaReq && (!bus.cpuReq || !grant_dma_q);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_dma_d = grant_dma_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cpuReq || bus.dmaReq) begin
          grant_dma_d = pick_dma;
          we_d        = pick_dma ? bus.dmaWe        : bus.cpuWe;
          adr_d       = pick_dma ? bus.dmaAdr       : bus.cpuAdr;
          wdata_d     = pick_dma ? bus.dmaWriteData : bus.cpuWriteData;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (grant_dma_q) dma_rdata_d = bus.memData;
            else             cpu_rdata_d = bus.memData;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_dma_q <= 1'b1;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_dma_q <= grant_dma_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.memAdr       = adr_q;
  assign bus.memWriteData = wdata_q;
  assign bus.memWrite     = (state_q == ACCESS) && we_q;
  assign bus.memRead      = (state_q == ACCESS) && !we_q;
  assign bus.cpuAck       = (state_q == DONE) && !grant_dma_q;
  assign bus.dmaAck       = (state_q == DONE) && grant_dma_q;
  assign bus.cpuReadData  = cpu_rdata_q;
  assign bus.dmaReadData  = dma_rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.grantDma     = grant_dma_q;
endmodule
